// File: rtl/de1_soc_p2b_pkg.sv
// Shared constants for the HPS master packets-to-bytes encoder: in-band marker
// bytes, the 3-bit FSM state encoding and the escape test used on channel and data.
package de1_soc_p2b_pkg;

    // In-band marker bytes and the XOR applied to an escaped byte
    localparam logic [7:0] P2B_SOP  = 8'h7A;
    localparam logic [7:0] P2B_EOP  = 8'h7B;
    localparam logic [7:0] P2B_CHAN = 8'h7C;
    localparam logic [7:0] P2B_ESC  = 8'h7D;
    localparam logic [7:0] P2B_XOR  = 8'h20;

    // Encoder FSM states, in the order the bytes of one beat leave the block
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CH_MARK  = 3'd1;
    localparam logic [2:0] ST_CH_ESC   = 3'd2;
    localparam logic [2:0] ST_CH_BYTE  = 3'd3;
    localparam logic [2:0] ST_SOP_MARK = 3'd4;
    localparam logic [2:0] ST_EOP_MARK = 3'd5;
    localparam logic [2:0] ST_D_ESC    = 3'd6;
    localparam logic [2:0] ST_D_BYTE   = 3'd7;

    // A payload byte collides with the marker set exactly when it lies in 0x7A..0x7D
    function automatic logic p2b_needs_esc(input logic [7:0] b);
        return (b >= P2B_SOP) && (b <= P2B_ESC);
    endfunction

endpackage

// File: rtl/de1_soc_p2b_escape.sv
// Combinational escape helper: flags a byte that collides with a marker and
// provides the substitute byte that follows the ESC marker on the wire.
module de1_soc_p2b_escape
    import de1_soc_p2b_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       needs_esc_o,
    output logic [7:0] escaped_o
);

    assign needs_esc_o = p2b_needs_esc(byte_i);
    assign escaped_o   = byte_i ^ P2B_XOR;

endmodule

// File: rtl/de1_soc_alternative_hps_master_p2b_encoder.sv
// Avalon-ST packets-to-bytes encoder. Each accepted beat is held in registers
// and walked out as [CHAN ch] [SOP] [EOP] data, with ch and data escaped when
// they collide with a marker. The last data byte can overlap the next accept so
// plain payload streams at one byte per cycle.
module de1_soc_alternative_hps_master_p2b_encoder
    import de1_soc_p2b_pkg::*;
#(
    parameter int ENCODE_CHANNEL = 1,
    parameter int CHANNEL_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic [CHANNEL_W-1:0] in_channel,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data
);

    logic [2:0] state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] chan_q, chan_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       ready_q;

    logic       accept;
    logic [7:0] chanExt;
    logic [2:0] firstState;
    logic [2:0] dataState;
    logic       chanNeedsEsc;
    logic [7:0] chanEscaped;
    logic       dataNeedsEsc;
    logic [7:0] dataEscaped;

    de1_soc_p2b_escape u_chan_esc (
        .byte_i      (chan_q),
        .needs_esc_o (chanNeedsEsc),
        .escaped_o   (chanEscaped)
    );

    de1_soc_p2b_escape u_data_esc (
        .byte_i      (data_q),
        .needs_esc_o (dataNeedsEsc),
        .escaped_o   (dataEscaped)
    );

    assign chanExt   = 8'(in_channel);
    assign out_valid = (state_q != ST_IDLE);
    assign in_ready  = ready_q && ((state_q == ST_IDLE) || ((state_q == ST_D_BYTE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign dataState = dataNeedsEsc ? ST_D_ESC : ST_D_BYTE;

    // Pick the first state a freshly offered beat needs, skipping everything it does not use
    always_comb begin
        firstState = ST_D_BYTE;
        if (in_startofpacket && (ENCODE_CHANNEL != 0)) begin
            firstState = ST_CH_MARK;
        end else if (in_startofpacket) begin
            firstState = ST_SOP_MARK;
        end else if (in_endofpacket) begin
            firstState = ST_EOP_MARK;
        end else if (p2b_needs_esc(in_data)) begin
            firstState = ST_D_ESC;
        end
    end

    // Step through the byte sequence of the held beat; every move waits for the downstream handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = firstState;
            end
            ST_CH_MARK: begin
                if (out_ready) state_d = chanNeedsEsc ? ST_CH_ESC : ST_CH_BYTE;
            end
            ST_CH_ESC: begin
                if (out_ready) state_d = ST_CH_BYTE;
            end
            ST_CH_BYTE: begin
                if (out_ready) state_d = ST_SOP_MARK;
            end
            ST_SOP_MARK: begin
                if (out_ready) state_d = eop_q ? ST_EOP_MARK : dataState;
            end
            ST_EOP_MARK: begin
                if (out_ready) state_d = dataState;
            end
            ST_D_ESC: begin
                if (out_ready) state_d = ST_D_BYTE;
            end
            ST_D_BYTE: begin
                if (out_ready) state_d = accept ? firstState : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the beat on accept; the channel is only meaningful on the first beat of a packet
    always_comb begin
        data_d = data_q;
        chan_d = chan_q;
        sop_d  = sop_q;
        eop_d  = eop_q;
        if (accept) begin
            data_d = in_data;
            sop_d  = in_startofpacket;
            eop_d  = in_endofpacket;
            if (in_startofpacket) chan_d = chanExt;
        end
    end

    // Output byte depends only on the state and the held beat, so it cannot move while stalled
    always_comb begin
        out_data = 8'h00;
        case (state_q)
            ST_CH_MARK:  out_data = P2B_CHAN;
            ST_CH_ESC:   out_data = P2B_ESC;
            ST_CH_BYTE:  out_data = chanNeedsEsc ? chanEscaped : chan_q;
            ST_SOP_MARK: out_data = P2B_SOP;
            ST_EOP_MARK: out_data = P2B_EOP;
            ST_D_ESC:    out_data = P2B_ESC;
            ST_D_BYTE:   out_data = dataNeedsEsc ? dataEscaped : data_q;
            default:     out_data = 8'h00;
        endcase
    end

    // State and holding registers; ready_q releases acceptance one clock edge after reset lifts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            chan_q  <= 8'h00;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            ready_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_de1_soc_alternative_hps_master_p2b_encoder.sv
// Self-checking bench for the p2b encoder. Drives directed beats and random
// packets, predicts the byte stream from the encoding rules, and decodes the
// observed stream back into beats the way a host would.
module tb_de1_soc_alternative_hps_master_p2b_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       inValid, bInValid, inSop, inEop, outReady;
    logic [7:0] inData, inChannel;
    logic       inReady, outValid, bInReady, bOutValid;
    logic [7:0] outData, bOutData;

    logic [7:0]  expA[$];
    logic [7:0]  expB[$];
    logic [17:0] sentBeats[$];

    int         checkCount = 0;
    int         passCount  = 0;
    int         pendingA, pendingB;
    bit         modelReady = 1'b0;
    bit         lastAccA   = 1'b0;
    bit         lastAccB   = 1'b0;
    bit         prevStall  = 1'b0;
    bit         randomReady = 1'b0;
    logic [7:0] prevData;
    logic [7:0] expByte;
    bit         decEsc, decChanNext, decSop, decEop;
    logic [7:0] decChan;

    de1_soc_alternative_hps_master_p2b_encoder #(.ENCODE_CHANNEL(1), .CHANNEL_W(8)) dutA (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_ready         (inReady),
        .in_valid         (inValid),
        .in_data          (inData),
        .in_channel       (inChannel),
        .in_startofpacket (inSop),
        .in_endofpacket   (inEop),
        .out_ready        (outReady),
        .out_valid        (outValid),
        .out_data         (outData)
    );

    de1_soc_alternative_hps_master_p2b_encoder #(.ENCODE_CHANNEL(0), .CHANNEL_W(8)) dutB (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_ready         (bInReady),
        .in_valid         (bInValid),
        .in_data          (inData),
        .in_channel       (inChannel),
        .in_startofpacket (inSop),
        .in_endofpacket   (inEop),
        .out_ready        (outReady),
        .out_valid        (bOutValid),
        .out_data         (bOutData)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic pushByte(input logic [7:0] b, input bit toA);
        if (toA) expA.push_back(b);
        else expB.push_back(b);
    endtask

    task automatic pushEscaped(input logic [7:0] b, input bit toA);
        if (b >= 8'h7A && b <= 8'h7D) begin
            pushByte(8'h7D, toA);
            pushByte(b ^ 8'h20, toA);
        end else begin
            pushByte(b, toA);
        end
    endtask

    task automatic pushEncoded(input logic [7:0] d, input logic [7:0] ch, input logic s, input logic e,
                               input bit enc, input bit toA);
        if (s && enc) begin
            pushByte(8'h7C, toA);
            pushEscaped(ch, toA);
        end
        if (s) pushByte(8'h7A, toA);
        if (e) pushByte(8'h7B, toA);
        pushEscaped(d, toA);
    endtask

    task automatic deliverValue(input logic [7:0] v);
        logic [17:0] beat;
        if (decChanNext) begin
            decChan     = v;
            decChanNext = 1'b0;
        end else begin
            if (sentBeats.size() != 0) begin
                beat = sentBeats.pop_front();
                checkOutput("A_decodedBeat",
                            {14'd0, decSop, decEop, (decSop ? decChan : 8'h00), v},
                            {14'd0, beat[17], beat[16], (beat[17] ? beat[15:8] : 8'h00), beat[7:0]});
            end
            decSop = 1'b0;
            decEop = 1'b0;
        end
    endtask

    task automatic decodeByte(input logic [7:0] x);
        if (decEsc) begin
            decEsc = 1'b0;
            deliverValue(x ^ 8'h20);
        end else begin
            case (x)
                8'h7C:   decChanNext = 1'b1;
                8'h7A:   decSop = 1'b1;
                8'h7B:   decEop = 1'b1;
                8'h7D:   decEsc = 1'b1;
                default: deliverValue(x);
            endcase
        end
    endtask

    // The model is able to accept again one clock edge after reset is released
    always @(posedge clk) if (reset_n) modelReady = 1'b1;

    // Random downstream backpressure during the random phase
    always @(posedge clk) begin
        #1;
        if (randomReady) outReady = ($urandom_range(0, 1) == 1);
    end

    // Monitor: sample on the falling edge, compare with the model, then record the handshakes of the coming edge
    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("rst_A_outValid", {31'd0, outValid}, 32'd0);
            checkOutput("rst_A_outData", {24'd0, outData}, 32'd0);
            checkOutput("rst_A_inReady", {31'd0, inReady}, 32'd0);
            checkOutput("rst_B_outValid", {31'd0, bOutValid}, 32'd0);
            checkOutput("rst_B_inReady", {31'd0, bInReady}, 32'd0);
            expA.delete();
            expB.delete();
            sentBeats.delete();
            decEsc = 0; decChanNext = 0; decSop = 0; decEop = 0;
            modelReady = 1'b0;
            lastAccA = 1'b0;
            lastAccB = 1'b0;
            prevStall = 1'b0;
        end else begin
            pendingA = expA.size();
            pendingB = expB.size();
            checkOutput("A_outValid", {31'd0, outValid}, {31'd0, pendingA != 0});
            checkOutput("A_inReady", {31'd0, inReady},
                        {31'd0, modelReady && (pendingA == 0 || (pendingA == 1 && outReady))});
            checkOutput("B_outValid", {31'd0, bOutValid}, {31'd0, pendingB != 0});
            checkOutput("B_inReady", {31'd0, bInReady},
                        {31'd0, modelReady && (pendingB == 0 || (pendingB == 1 && outReady))});
            if (prevStall) checkOutput("A_stableWhileStalled", {24'd0, outData}, {24'd0, prevData});
            if (outValid && outReady && pendingA != 0) begin
                expByte = expA.pop_front();
                checkOutput("A_byte", {24'd0, outData}, {24'd0, expByte});
                decodeByte(outData);
            end
            if (bOutValid && outReady && pendingB != 0) begin
                expByte = expB.pop_front();
                checkOutput("B_byte", {24'd0, bOutData}, {24'd0, expByte});
            end
            prevStall = outValid && !outReady;
            prevData  = outData;
            lastAccA  = inValid && inReady;
            lastAccB  = bInValid && bInReady;
            if (lastAccA) begin
                pushEncoded(inData, inChannel, inSop, inEop, 1'b1, 1'b1);
                sentBeats.push_back({inSop, inEop, inChannel, inData});
            end
            if (lastAccB) pushEncoded(inData, inChannel, inSop, inEop, 1'b0, 1'b0);
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] ch, input logic s, input logic e,
                                 input bit toA, input bit toB);
        int waited;
        inData    = d;
        inChannel = ch;
        inSop     = s;
        inEop     = e;
        inValid   = toA;
        bInValid  = toB;
        waited    = 0;
        while ((inValid || bInValid) && waited < 200) begin
            @(posedge clk);
            #1;
            if (lastAccA) inValid = 1'b0;
            if (lastAccB) bInValid = 1'b0;
            waited++;
        end
        checkOutput("acceptPending", {31'd0, inValid || bInValid}, 32'd0);
        inValid  = 1'b0;
        bInValid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        inValid  = 1'b0;
        bInValid = 1'b0;
        waited   = 0;
        while ((expA.size() != 0 || expB.size() != 0 || outValid || bOutValid) && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("drainLeft", expA.size() + expB.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        int         beats;
        reset_n  = 1'b0;
        inValid  = 1'b0;
        bInValid = 1'b0;
        inData   = 8'h00;
        inChannel = 8'h00;
        inSop    = 1'b0;
        inEop    = 1'b0;
        outReady = 1'b1;
        decEsc = 0; decChanNext = 0; decSop = 0; decEop = 0; decChan = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single-beat packet with channel");
        applyStimulus(8'h41, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        $display("[TB] mid-packet escapes");
        applyStimulus(8'h7D, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h7A, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h7E, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        $display("[TB] escaped channel, with and without channel encoding");
        applyStimulus(8'h01, 8'h7B, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();

        $display("[TB] back-to-back plain data");
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h12, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        $display("[TB] reset in the middle of an escape pair");
        applyStimulus(8'h7C, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_asyncOutValid", {31'd0, outValid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h33, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        $display("[TB] random packets with random backpressure");
        randomReady = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            beats = $urandom_range(1, 3);
            for (int b = 0; b < beats; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 2) == 0) rd = 8'(8'h78 + $urandom_range(0, 7));
                else rd = 8'($urandom);
                applyStimulus(rd, 8'($urandom), (b == 0), (b == beats - 1), 1'b1, 1'b0);
            end
        end
        randomReady = 1'b0;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        drain();
        checkOutput("beatsNotDecoded", sentBeats.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
